// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use interlock for the ID stage of a 5-stage MIPS pipeline.
// Resolves NRD source ports against EXE/MEM/WB writers, with a stall watchdog and perf counters.
module fwd_hazard_unit #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int NRD       = 2,
  parameter int FWD_EN    = 1,
  parameter int MAX_STALL = 15,
  parameter int CNT_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [NRD-1:0]        id_used,
  input  logic [NRD*ADDR_W-1:0] id_addr,
  input  logic [NRD*DATA_W-1:0] id_rf_data,
  input  logic                  exe_wen,
  input  logic                  exe_load,
  input  logic [ADDR_W-1:0]     exe_waddr,
  input  logic [DATA_W-1:0]     exe_wdata,
  input  logic                  mem_wen,
  input  logic                  mem_load,
  input  logic [ADDR_W-1:0]     mem_waddr,
  input  logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_ld_rdy,
  input  logic                  wb_wen,
  input  logic [ADDR_W-1:0]     wb_waddr,
  input  logic [DATA_W-1:0]     wb_wdata,
  output logic [NRD*DATA_W-1:0] id_op_data,
  output logic [NRD*2-1:0]      fwd_sel,
  output logic                  stall_id,
  output logic                  wdog_err,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      fwd_cnt
);

  localparam int SC_W = $clog2(MAX_STALL + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(MAX_STALL);
  localparam bit FWD_ON = (FWD_EN != 0);

  typedef enum logic [0:0] {RUN = 1'b0, STALL = 1'b1} state_t;

  state_t            state_r;
  logic [SC_W-1:0]   sc_r;
  logic [SC_W-1:0]   sc_inc_s;
  logic [ADDR_W-1:0] addr_s;
  logic              live_s;
  logic              m_exe_s;
  logic              m_mem_s;
  logic              m_wb_s;
  logic [1:0]        sel_s;
  logic [DATA_W-1:0] data_s;
  logic              haz_s;
  logic              fwd_any_s;

  // Per-port resolution: youngest matching writer wins; an unready load stalls instead.
  always_comb begin
    id_op_data = id_rf_data;
    fwd_sel    = {(NRD*2){1'b0}};
    stall_id   = 1'b0;
    fwd_any_s  = 1'b0;
    addr_s     = {ADDR_W{1'b0}};
    live_s     = 1'b0;
    m_exe_s    = 1'b0;
    m_mem_s    = 1'b0;
    m_wb_s     = 1'b0;
    sel_s      = 2'b00;
    data_s     = {DATA_W{1'b0}};
    haz_s      = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      addr_s  = id_addr[i*ADDR_W +: ADDR_W];
      live_s  = ~rst & id_valid & id_used[i] & (addr_s != {ADDR_W{1'b0}});
      m_exe_s = live_s & exe_wen & (exe_waddr == addr_s);
      m_mem_s = live_s & mem_wen & (mem_waddr == addr_s);
      m_wb_s  = live_s & wb_wen  & (wb_waddr  == addr_s);
      sel_s   = 2'b00;
      data_s  = id_rf_data[i*DATA_W +: DATA_W];
      haz_s   = 1'b0;
      if (!FWD_ON) begin
        haz_s = m_exe_s | m_mem_s | m_wb_s;
      end else if (m_exe_s) begin
        if (exe_load) begin
          haz_s = 1'b1;
        end else begin
          sel_s  = 2'b01;
          data_s = exe_wdata;
        end
      end else if (m_mem_s) begin
        if (mem_load && !mem_ld_rdy) begin
          haz_s = 1'b1;
        end else begin
          sel_s  = 2'b10;
          data_s = mem_wdata;
        end
      end else if (m_wb_s) begin
        sel_s  = 2'b11;
        data_s = wb_wdata;
      end else begin
        sel_s = 2'b00;
      end
      id_op_data[i*DATA_W +: DATA_W] = data_s;
      fwd_sel[i*2 +: 2]              = sel_s;
      stall_id                       = stall_id | haz_s;
      fwd_any_s                      = fwd_any_s | (sel_s != 2'b00);
    end
  end

  assign sc_inc_s = (sc_r == SC_MAX) ? sc_r : sc_r + 1'b1;

  // Stall-tracking FSM, sticky watchdog and saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= RUN;
      sc_r      <= {SC_W{1'b0}};
      wdog_err  <= 1'b0;
      stall_cnt <= {CNT_W{1'b0}};
      fwd_cnt   <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        RUN: begin
          if (stall_id) begin
            state_r <= STALL;
            sc_r    <= sc_inc_s;
          end else begin
            sc_r <= {SC_W{1'b0}};
          end
        end
        STALL: begin
          if (stall_id) begin
            sc_r <= sc_inc_s;
          end else begin
            state_r <= RUN;
            sc_r    <= {SC_W{1'b0}};
          end
        end
        default: begin
          state_r <= RUN;
          sc_r    <= {SC_W{1'b0}};
        end
      endcase
      // sc_inc_s counts the current stall cycle, so MAX_STALL stalled cycles trip the flag.
      if (stall_id && (sc_inc_s == SC_MAX)) begin
        wdog_err <= 1'b1;
      end
      if (stall_id && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (!stall_id && fwd_any_s && (fwd_cnt != {CNT_W{1'b1}})) begin
        fwd_cnt <= fwd_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed scenarios plus randomized traffic
// checked against a stage-list reference model; three instances cover FWD_EN=0 and CNT_W=4.
module tb_fwd_hazard_unit;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;
  localparam int MAXS = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst, id_valid;
  logic [NRD-1:0]      id_used;
  logic [NRD*AW-1:0]   id_addr;
  logic [NRD*DW-1:0]   id_rf_data;
  logic                exe_wen, exe_load, mem_wen, mem_load, mem_ld_rdy, wb_wen;
  logic [AW-1:0]       exe_waddr, mem_waddr, wb_waddr;
  logic [DW-1:0]       exe_wdata, mem_wdata, wb_wdata;

  logic [NRD*DW-1:0]   op_a, op_b, op_c;
  logic [NRD*2-1:0]    sel_a, sel_b, sel_c;
  logic                stall_a, stall_b, stall_c, wdog_a, wdog_b, wdog_c;
  logic [31:0]         scnt_a, fcnt_a, scnt_b, fcnt_b;
  logic [3:0]          scnt_c, fcnt_c;

  int checks = 0;
  int errors = 0;

  // reference model state
  longint m_scnt, m_fcnt, m_scnt4, m_consec;
  bit     m_wdog;

  fwd_hazard_unit u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_used(id_used), .id_addr(id_addr),
    .id_rf_data(id_rf_data), .exe_wen(exe_wen), .exe_load(exe_load), .exe_waddr(exe_waddr),
    .exe_wdata(exe_wdata), .mem_wen(mem_wen), .mem_load(mem_load), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_ld_rdy(mem_ld_rdy), .wb_wen(wb_wen), .wb_waddr(wb_waddr),
    .wb_wdata(wb_wdata), .id_op_data(op_a), .fwd_sel(sel_a), .stall_id(stall_a),
    .wdog_err(wdog_a), .stall_cnt(scnt_a), .fwd_cnt(fcnt_a));

  fwd_hazard_unit #(.FWD_EN(0)) u_nofwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_used(id_used), .id_addr(id_addr),
    .id_rf_data(id_rf_data), .exe_wen(exe_wen), .exe_load(exe_load), .exe_waddr(exe_waddr),
    .exe_wdata(exe_wdata), .mem_wen(mem_wen), .mem_load(mem_load), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_ld_rdy(mem_ld_rdy), .wb_wen(wb_wen), .wb_waddr(wb_waddr),
    .wb_wdata(wb_wdata), .id_op_data(op_b), .fwd_sel(sel_b), .stall_id(stall_b),
    .wdog_err(wdog_b), .stall_cnt(scnt_b), .fwd_cnt(fcnt_b));

  fwd_hazard_unit #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_used(id_used), .id_addr(id_addr),
    .id_rf_data(id_rf_data), .exe_wen(exe_wen), .exe_load(exe_load), .exe_waddr(exe_waddr),
    .exe_wdata(exe_wdata), .mem_wen(mem_wen), .mem_load(mem_load), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_ld_rdy(mem_ld_rdy), .wb_wen(wb_wen), .wb_waddr(wb_waddr),
    .wb_wdata(wb_wdata), .id_op_data(op_c), .fwd_sel(sel_c), .stall_id(stall_c),
    .wdog_err(wdog_c), .stall_cnt(scnt_c), .fwd_cnt(fcnt_c));

  // Writers listed youngest first; the first matching writer decides each port.
  function automatic void model(input bit fwd_en, output logic [NRD*DW-1:0] op,
                                output logic [NRD*2-1:0] sel, output logic stall);
    logic [AW-1:0] wa [3];
    logic          we [3];
    logic          blk [3];
    logic [DW-1:0] wd [3];
    wa  = '{exe_waddr, mem_waddr, wb_waddr};
    we  = '{exe_wen, mem_wen, wb_wen};
    blk = '{exe_load, mem_load & ~mem_ld_rdy, 1'b0};
    wd  = '{exe_wdata, mem_wdata, wb_wdata};
    op    = id_rf_data;
    sel   = '0;
    stall = 1'b0;
    for (int p = 0; p < NRD; p++) begin
      logic [AW-1:0] a;
      a = id_addr[p*AW +: AW];
      if (!rst && id_valid && id_used[p] && a != 0) begin
        for (int s = 0; s < 3; s++) begin
          if (we[s] && wa[s] == a) begin
            if (!fwd_en || blk[s]) begin
              stall = 1'b1;
            end else begin
              sel[p*2 +: 2]   = 2'(s + 1);
              op[p*DW +: DW]  = wd[s];
            end
            break;
          end
        end
      end
    end
  endfunction

  // One clock edge; model counters follow the edge, then outputs settle for sampling.
  task automatic advance();
    logic [NRD*DW-1:0] o;
    logic [NRD*2-1:0]  s;
    logic              st;
    model(1'b1, o, s, st);
    @(posedge clk);
    if (rst) begin
      m_scnt = 0; m_fcnt = 0; m_scnt4 = 0; m_consec = 0; m_wdog = 1'b0;
    end else if (st) begin
      if (m_scnt < 64'hFFFF_FFFF) m_scnt++;
      if (m_scnt4 < 15) m_scnt4++;
      m_consec++;
      if (m_consec >= MAXS) m_wdog = 1'b1;
    end else begin
      m_consec = 0;
      if (s != '0 && m_fcnt < 64'hFFFF_FFFF) m_fcnt++;
    end
    #1;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_used = '0; id_addr = '0; id_rf_data = {32'hA5A5_0001, 32'h5A5A_0000};
    exe_wen = 1'b0; exe_load = 1'b0; exe_waddr = '0; exe_wdata = '0;
    mem_wen = 1'b0; mem_load = 1'b0; mem_waddr = '0; mem_wdata = '0; mem_ld_rdy = 1'b0;
    wb_wen = 1'b0; wb_waddr = '0; wb_wdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    #4;
    advance();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    id_valid = 1'b1; id_used = 2'b11; id_addr = {5'd3, 5'd3};
    exe_wen = 1'b1; exe_load = 1'b1; exe_waddr = 5'd3;
    #4;
    checks++; if (stall_a !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b want 0", stall_a); end
    checks++; if (sel_a !== 4'b0000) begin errors++; $display("FAIL reset_sel got %b want 0000", sel_a); end
    checks++; if (op_a !== id_rf_data) begin errors++; $display("FAIL reset_op got %h want %h", op_a, id_rf_data); end
    advance();
    checks++; if (scnt_a !== 32'd0 || fcnt_a !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", scnt_a, fcnt_a); end
    checks++; if (wdog_a !== 1'b0) begin errors++; $display("FAIL reset_wdog got %0b want 0", wdog_a); end
    rst = 1'b0;
  endtask

  task automatic test_exe_fwd();
    do_reset();
    id_valid = 1'b1; id_used = 2'b01; id_addr = {5'd0, 5'd3};
    exe_wen = 1'b1; exe_waddr = 5'd3; exe_wdata = 32'h11;
    #4;
    checks++; if (sel_a[1:0] !== 2'b01) begin errors++; $display("FAIL exe_sel got %b want 01", sel_a[1:0]); end
    checks++; if (op_a[31:0] !== 32'h11) begin errors++; $display("FAIL exe_op got %h want 11", op_a[31:0]); end
    checks++; if (stall_a !== 1'b0) begin errors++; $display("FAIL exe_stall got %0b want 0", stall_a); end
    checks++; if (fcnt_a !== 32'd0) begin errors++; $display("FAIL exe_fcnt0 got %0d want 0", fcnt_a); end
    advance();
    checks++; if (fcnt_a !== 32'd1) begin errors++; $display("FAIL exe_fcnt1 got %0d want 1", fcnt_a); end
  endtask

  task automatic test_priority();
    idle();
    id_valid = 1'b1; id_used = 2'b11; id_addr = {5'd3, 5'd3};
    exe_wen = 1'b1; exe_waddr = 5'd3; exe_wdata = 32'h22;
    mem_wen = 1'b1; mem_waddr = 5'd3; mem_wdata = 32'h33;
    wb_wen = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'h44;
    #4;
    checks++; if (sel_a !== 4'b0101) begin errors++; $display("FAIL prio_sel got %b want 0101", sel_a); end
    checks++; if (op_a !== {32'h22, 32'h22}) begin errors++; $display("FAIL prio_op got %h want 22/22", op_a); end
    checks++; if (stall_b !== 1'b1 || sel_b !== 4'b0000) begin errors++; $display("FAIL prio_nofwd got stall %0b sel %b want 1 0000", stall_b, sel_b); end
    mem_wen = 1'b0; exe_wen = 1'b0;
    #1;
    checks++; if (sel_a !== 4'b1111 || op_a !== {32'h44, 32'h44}) begin errors++; $display("FAIL prio_wb got %b %h want 1111 44/44", sel_a, op_a); end
    #3;
    advance();
  endtask

  task automatic test_load_use();
    do_reset();
    id_valid = 1'b1; id_used = 2'b10; id_addr = {5'd5, 5'd0};
    exe_wen = 1'b1; exe_load = 1'b1; exe_waddr = 5'd5;
    #4;
    checks++; if (stall_a !== 1'b1) begin errors++; $display("FAIL lu_exe got %0b want 1", stall_a); end
    advance();
    exe_wen = 1'b0; exe_load = 1'b0;
    mem_wen = 1'b1; mem_load = 1'b1; mem_waddr = 5'd5; mem_ld_rdy = 1'b0;
    #4;
    checks++; if (stall_a !== 1'b1) begin errors++; $display("FAIL lu_mem_wait got %0b want 1", stall_a); end
    advance();
    mem_ld_rdy = 1'b1; mem_wdata = 32'hBEEF;
    #4;
    checks++; if (stall_a !== 1'b0) begin errors++; $display("FAIL lu_rdy_stall got %0b want 0", stall_a); end
    checks++; if (sel_a[3:2] !== 2'b10 || op_a[63:32] !== 32'hBEEF) begin errors++; $display("FAIL lu_fwd got %b %h want 10 beef", sel_a[3:2], op_a[63:32]); end
    checks++; if (scnt_a !== 32'd2) begin errors++; $display("FAIL lu_scnt got %0d want 2", scnt_a); end
    advance();
  endtask

  task automatic test_zero_reg();
    do_reset();
    id_valid = 1'b1; id_used = 2'b01; id_addr = {5'd0, 5'd0}; id_rf_data = {32'h0, 32'h1234_5678};
    exe_wen = 1'b1; mem_wen = 1'b1; wb_wen = 1'b1; exe_wdata = 32'h1; mem_wdata = 32'h2; wb_wdata = 32'h3;
    #4;
    checks++; if (sel_a !== 4'b0000 || op_a[31:0] !== 32'h1234_5678) begin errors++; $display("FAIL r0_fwd got %b %h want 0000 12345678", sel_a, op_a[31:0]); end
    checks++; if (stall_a !== 1'b0 || stall_b !== 1'b0) begin errors++; $display("FAIL r0_stall got %0b/%0b want 0/0", stall_a, stall_b); end
    exe_wen = 1'b0; mem_wen = 1'b0; wb_waddr = 5'd9; id_used = 2'b11; id_addr = {5'd9, 5'd0};
    #1;
    checks++; if (stall_b !== 1'b1 || sel_b !== 4'b0000) begin errors++; $display("FAIL nofwd_wb got %0b %b want 1 0000", stall_b, sel_b); end
    checks++; if (stall_a !== 1'b0 || sel_a !== 4'b1100) begin errors++; $display("FAIL fwd_wb got %0b %b want 0 1100", stall_a, sel_a); end
    #3;
    advance();
  endtask

  task automatic test_watchdog();
    do_reset();
    id_valid = 1'b1; id_used = 2'b01; id_addr = {5'd0, 5'd7};
    mem_wen = 1'b1; mem_load = 1'b1; mem_waddr = 5'd7; mem_ld_rdy = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      #4;
      advance();
      checks++;
      if (wdog_a !== (k >= MAXS)) begin errors++; $display("FAIL wdog_edge%0d got %0b want %0b", k, wdog_a, k >= MAXS); end
    end
    checks++; if (scnt_c !== 4'hF) begin errors++; $display("FAIL sat_scnt got %h want f", scnt_c); end
    checks++; if (scnt_a !== 32'd20) begin errors++; $display("FAIL wdog_scnt got %0d want 20", scnt_a); end
    mem_ld_rdy = 1'b1;
    #4;
    checks++; if (stall_a !== 1'b0) begin errors++; $display("FAIL wdog_clear got %0b want 0", stall_a); end
    advance();
    checks++; if (wdog_a !== 1'b1) begin errors++; $display("FAIL wdog_sticky got %0b want 1", wdog_a); end
    mem_ld_rdy = 1'b0;
    #1;
    checks++; if (stall_a !== 1'b1) begin errors++; $display("FAIL wdog_restall got %0b want 1", stall_a); end
    rst = 1'b1;
    #1;
    checks++; if (stall_a !== 1'b0) begin errors++; $display("FAIL rst_drop got %0b want 0", stall_a); end
    #2;
    advance();
    checks++; if (wdog_a !== 1'b0 || scnt_a !== 32'd0 || fcnt_a !== 32'd0 || scnt_c !== 4'd0) begin
      errors++; $display("FAIL wdog_rst got %0b %0d %0d %0d want 0 0 0 0", wdog_a, scnt_a, fcnt_a, scnt_c);
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [NRD*DW-1:0] eo, eob;
    logic [NRD*2-1:0]  es, esb;
    logic              est, estb;
    for (int n = 0; n < 400; n++) begin
      rst        = ($urandom_range(0, 59) == 0);
      id_valid   = ($urandom_range(0, 7) != 0);
      id_used    = NRD'($urandom);
      id_addr    = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      id_rf_data = {$urandom, $urandom};
      exe_wen    = 1'($urandom); exe_load = ($urandom_range(0, 3) == 0);
      exe_waddr  = 5'($urandom_range(0, 3)); exe_wdata = $urandom;
      mem_wen    = 1'($urandom); mem_load = ($urandom_range(0, 2) == 0);
      mem_waddr  = 5'($urandom_range(0, 3)); mem_wdata = $urandom; mem_ld_rdy = 1'($urandom);
      wb_wen     = 1'($urandom); wb_waddr = 5'($urandom_range(0, 3)); wb_wdata = $urandom;
      #4;
      model(1'b1, eo, es, est);
      model(1'b0, eob, esb, estb);
      checks++; if (op_a !== eo || sel_a !== es || stall_a !== est) begin
        errors++; $display("FAIL rnd_fwd n=%0d got %h %b %0b want %h %b %0b", n, op_a, sel_a, stall_a, eo, es, est);
      end
      checks++; if (op_b !== eob || sel_b !== esb || stall_b !== estb) begin
        errors++; $display("FAIL rnd_nofwd n=%0d got %h %b %0b want %h %b %0b", n, op_b, sel_b, stall_b, eob, esb, estb);
      end
      advance();
      checks++; if (scnt_a !== 32'(m_scnt) || fcnt_a !== 32'(m_fcnt) || wdog_a !== m_wdog) begin
        errors++; $display("FAIL rnd_cnt n=%0d got %0d %0d %0b want %0d %0d %0b", n, scnt_a, fcnt_a, wdog_a, m_scnt, m_fcnt, m_wdog);
      end
      checks++; if (scnt_c !== 4'(m_scnt4) || wdog_c !== m_wdog) begin
        errors++; $display("FAIL rnd_sat n=%0d got %0d %0b want %0d %0b", n, scnt_c, wdog_c, m_scnt4, m_wdog);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    m_scnt = 0; m_fcnt = 0; m_scnt4 = 0; m_consec = 0; m_wdog = 1'b0;
    test_reset();
    test_exe_fwd();
    test_priority();
    test_load_use();
    test_zero_reg();
    test_watchdog();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
